// File: rtl/double_ball_timer.sv
// Purpose : times the double-ball bonus in video frames, blinks the indicator sprite near expiry,
//           and flags the goal that consumes the bonus.
// Latency : 1 cycle; all outputs registered on the CLK edge that samples the causing input.
// Backpressure: none; single-cycle event pulses are consumed as they arrive, priority goal > pickup > startOfFrame.
//
// Ports:
//   CLK, RESETn          clock, asynchronous active-low reset
//   startOfFrame         one-cycle pulse per video frame
//   pickup               one-cycle pulse when the bonus is collected
//   goal                 one-cycle pulse when any goal is scored
//   db_enaN              sprite enable (1 shows the indicator)
//   double_active        bonus armed (ACTIVE or WARN)
//   goal_doubled         one-cycle pulse when a goal consumes the bonus
//   frames_left[10:0]    remaining bonus frames, 0 when idle
module double_ball_timer #(
    parameter int DURATION_FRAMES = 600,
    parameter int WARN_FRAMES     = 120,
    parameter int BLINK_HALF      = 8
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        startOfFrame,
    input  logic        pickup,
    input  logic        goal,
    output logic        db_enaN,
    output logic        double_active,
    output logic        goal_doubled,
    output logic [10:0] frames_left
);

    // Blink counter only ever needs to hold BLINK_HALF-1; keep at least one bit.
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [10:0]   DUR_LD     = 11'(DURATION_FRAMES);
    localparam logic [10:0]   WARN_TH    = 11'(WARN_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        WARN   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   fl_q, fl_d;
    logic [10:0]   fl_dec;
    logic          db_q, db_d;
    logic          gd_q, gd_d;
    logic [BW-1:0] blink_q, blink_d;

    assign fl_dec = fl_q - 11'd1;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            fl_q    <= '0;
            db_q    <= 1'b0;
            gd_q    <= 1'b0;
            blink_q <= '0;
        end else begin
            state_q <= state_d;
            fl_q    <= fl_d;
            db_q    <= db_d;
            gd_q    <= gd_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fl_d    = fl_q;
        db_d    = db_q;
        gd_d    = 1'b0;
        blink_d = blink_q;

        case (state_q)
            IDLE: begin
                // A goal has nothing to consume here, so a simultaneous pickup still arms.
                if (pickup) begin
                    state_d = ACTIVE;
                    fl_d    = DUR_LD;
                    db_d    = 1'b1;
                    blink_d = '0;
                end
            end

            ACTIVE, WARN: begin
                if (goal) begin
                    // Goal consumes the bonus; any same-cycle pickup is dropped.
                    state_d = IDLE;
                    fl_d    = '0;
                    db_d    = 1'b0;
                    gd_d    = 1'b1;
                    blink_d = '0;
                end else if (pickup) begin
                    // Reload wins over a same-cycle frame tick: no decrement.
                    state_d = ACTIVE;
                    fl_d    = DUR_LD;
                    db_d    = 1'b1;
                    blink_d = '0;
                end else if (startOfFrame) begin
                    fl_d = fl_dec;
                    if (fl_dec == 11'd0) begin
                        // Expiry takes precedence over any blink toggle on the last frame.
                        state_d = IDLE;
                        db_d    = 1'b0;
                        blink_d = '0;
                    end else if (state_q == ACTIVE) begin
                        if (fl_dec <= WARN_TH) begin
                            state_d = WARN;
                            db_d    = 1'b1;
                            blink_d = '0;
                        end
                    end else begin
                        // Counter counts completed frames of the current half-period.
                        if (blink_q == BLINK_LAST) begin
                            db_d    = ~db_q;
                            blink_d = '0;
                        end else begin
                            blink_d = blink_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                fl_d    = '0;
                db_d    = 1'b0;
                blink_d = '0;
            end
        endcase
    end

    assign db_enaN       = db_q;
    assign double_active = (state_q != IDLE);
    assign goal_doubled  = gd_q;
    assign frames_left   = fl_q;

endmodule

// File: tb/tb_double_ball_timer.sv
module tb_double_ball_timer;

    logic        CLK;
    logic        RESETn;
    logic        startOfFrame;
    logic        pickup;
    logic        goal;
    logic        db_enaN;
    logic        double_active;
    logic        goal_doubled;
    logic [10:0] frames_left;

    int checks;
    int errors;

    double_ball_timer #(
        .DURATION_FRAMES(10),
        .WARN_FRAMES    (4),
        .BLINK_HALF     (1)
    ) dut (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .startOfFrame (startOfFrame),
        .pickup       (pickup),
        .goal         (goal),
        .db_enaN      (db_enaN),
        .double_active(double_active),
        .goal_doubled (goal_doubled),
        .frames_left  (frames_left)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       sof;
        logic       pk;
        logic       gl;
        logic       db;
        logic       act;
        logic       gd;
        logic [10:0] fl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic sof, input logic pk, input logic gl,
                                input logic db, input logic act, input logic gd,
                                input int fl);
        vec_t v;
        v.sof = sof; v.pk = pk; v.gl = gl;
        v.db = db; v.act = act; v.gd = gd; v.fl = 11'(fl);
        vecs.push_back(v);
    endfunction

    task automatic check_outs(input string name, input logic db, input logic act,
                              input logic gd, input logic [10:0] fl);
        checks++;
        if (db_enaN !== db || double_active !== act || goal_doubled !== gd || frames_left !== fl) begin
            errors++;
            $display("FAIL %s: got db_enaN=%b double_active=%b goal_doubled=%b frames_left=%0d, expected %b %b %b %0d",
                     name, db_enaN, double_active, goal_doubled, frames_left, db, act, gd, fl);
        end
    endtask

    // Drive inputs mid-cycle, sample 1 time unit after the capturing edge.
    task automatic step(input logic sof, input logic pk, input logic gl);
        @(negedge CLK);
        startOfFrame = sof;
        pickup       = pk;
        goal         = gl;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        RESETn       = 1'b0;
        startOfFrame = 1'b0;
        pickup       = 1'b0;
        goal         = 1'b0;

        // 1. idle: frames and a goal do nothing
        for (int i = 0; i < 20; i++) add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // 2. full expiry
        add(0, 1, 0, 1, 1, 0, 10);
        for (int f = 9; f >= 4; f--) add(1, 0, 0, 1, 1, 0, f);
        add(1, 0, 0, 0, 1, 0, 3);
        add(1, 0, 0, 1, 1, 0, 2);
        add(1, 0, 0, 0, 1, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        // 3. goal mid-bonus, pulse lasts one cycle
        add(0, 1, 0, 1, 1, 0, 10);
        add(1, 0, 0, 1, 1, 0, 9);
        add(1, 0, 0, 1, 1, 0, 8);
        add(1, 0, 0, 1, 1, 0, 7);
        add(0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // 4. re-pickup in WARN returns to ACTIVE
        add(0, 1, 0, 1, 1, 0, 10);
        for (int f = 9; f >= 4; f--) add(1, 0, 0, 1, 1, 0, f);
        add(1, 0, 0, 0, 1, 0, 3);
        add(0, 1, 0, 1, 1, 0, 10);
        add(1, 0, 0, 1, 1, 0, 9);   // still ACTIVE: no toggle at 9
        // 5a. armed goal+pickup: consumed, pickup dropped
        add(0, 1, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // 5c. idle goal+pickup: arms, no pulse
        add(0, 1, 1, 1, 1, 0, 10);
        add(0, 0, 0, 1, 1, 0, 10);
        // 5b. pickup+frame: reload only
        add(1, 0, 0, 1, 1, 0, 9);
        add(1, 1, 0, 1, 1, 0, 10);
        // pickup+frame while in WARN with sprite hidden
        for (int f = 9; f >= 4; f--) add(1, 0, 0, 1, 1, 0, f);
        add(1, 0, 0, 0, 1, 0, 3);
        add(1, 1, 0, 1, 1, 0, 10);
        add(0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0);

        // reset state
        repeat (3) @(posedge CLK);
        #1;
        check_outs("reset_state", 0, 0, 0, 0);
        @(negedge CLK);
        RESETn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].sof, vecs[i].pk, vecs[i].gl);
            check_outs($sformatf("vec%0d", i), vecs[i].db, vecs[i].act, vecs[i].gd, vecs[i].fl);
        end

        // 6. asynchronous reset mid-WARN
        step(0, 1, 0);
        check_outs("rst_pickup", 1, 1, 0, 10);
        for (int f = 9; f >= 2; f--) step(1, 0, 0);
        check_outs("rst_prewarn", 1, 1, 0, 2);
        @(negedge CLK);
        startOfFrame = 1'b0;
        #2;
        RESETn = 1'b0;
        #1;
        check_outs("rst_async_clear", 0, 0, 0, 0);
        @(negedge CLK);
        RESETn = 1'b1;
        step(1, 0, 0);
        check_outs("rst_after_release_idle", 0, 0, 0, 0);
        step(0, 1, 0);
        check_outs("rst_fresh_pickup", 1, 1, 0, 10);
        step(1, 0, 0);
        check_outs("rst_fresh_frame", 1, 1, 0, 9);
        step(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
